// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the packet-locking round-robin arbiter.
package arbiter_pkg;

  // Arbiter control state: IDLE arbitrates, LOCK holds a grant for one packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Priority scheme selected by the MODE parameter.
  typedef enum int unsigned {
    ARB_FIXED = 0,
    ARB_RR    = 1
  } arb_mode_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder of arbitrary width.
module priority_encoder
  import arbiter_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG     = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     enc_in,
  output logic [WIDTH_LOG-1:0] enc_idx,
  output logic                 enc_vld
);

  assign enc_vld = |enc_in;

  if (IMPLEMENTATION == 0) begin : g_loop
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
      enc_idx = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (enc_in[i]) enc_idx = WIDTH_LOG'(i);
      end
    end
  end else begin : g_onehot
    logic [WIDTH-1:0] lowest_c;

    // Isolate the lowest set bit, then OR together the index of that single bit.
    assign lowest_c = enc_in & (~enc_in + WIDTH'(1));

    // Convert the one-hot lowest bit into its binary index.
    always_comb begin
      enc_idx = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (lowest_c[i]) enc_idx = enc_idx | WIDTH_LOG'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter_round_robin.sv
// N-way packet-locking arbiter: fixed or round-robin priority, grant held until last beat transfers.
module arbiter_round_robin
  import arbiter_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MODE           = 1,
  parameter int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG     = idx_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 grt_vld,
  output logic                 grt_lst,
  output logic [WIDTH_LOG-1:0] grt_idx,
  output logic                 grt_lck,
  input  logic                 grt_rdy
);

  localparam int unsigned SUM_W = WIDTH_LOG + 1;
  localparam logic [WIDTH_LOG-1:0] LAST_IDX = WIDTH_LOG'(WIDTH - 1);

  if (MODE > 1) begin : g_bad_mode
    $fatal(1, "arbiter_round_robin: MODE must be 0 (fixed) or 1 (round-robin)");
  end

  arb_state_t           state_q, state_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
  logic [WIDTH_LOG-1:0] grt_idx_q, grt_idx_d;

  logic [WIDTH-1:0]     rot_c;
  logic [WIDTH_LOG-1:0] enc_idx;
  logic                 enc_vld;
  logic [SUM_W-1:0]     sum_c;
  logic [WIDTH_LOG-1:0] winner_c;
  logic                 lock_c;
  logic                 xfer_c;

  // Rotate requests right by ptr so the encoder's bit 0 is the current top priority.
  always_comb begin
    int unsigned src;
    src   = 0;
    rot_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      src = i + 32'(ptr_q);
      if (src >= WIDTH) src = src - WIDTH;
      rot_c[i] = req_vld[WIDTH_LOG'(src)];
    end
  end

  priority_encoder #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc (
    .enc_in  (rot_c),
    .enc_idx (enc_idx),
    .enc_vld (enc_vld)
  );

  // Undo the rotation; WIDTH need not be a power of two, so wrap by compare.
  always_comb begin
    sum_c = SUM_W'(enc_idx) + SUM_W'(ptr_q);
    if (sum_c >= SUM_W'(WIDTH)) winner_c = WIDTH_LOG'(sum_c - SUM_W'(WIDTH));
    else                        winner_c = WIDTH_LOG'(sum_c);
  end

  assign lock_c = (state_q == LOCK);

  // Downstream side follows the locked requester; grt_rdy never feeds grt_vld.
  always_comb begin
    grt_vld = lock_c & req_vld[grt_idx_q];
    grt_lst = lock_c & req_lst[grt_idx_q];
    grt_lck = lock_c;
    grt_idx = grt_idx_q;
  end

  // Only the locked requester sees downstream ready.
  always_comb begin
    req_rdy = '0;
    if (lock_c) req_rdy[grt_idx_q] = grt_rdy;
  end

  assign xfer_c = grt_vld & grt_rdy;

  // Next state: arbitrate in IDLE, release on the last-beat transfer and advance the pointer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grt_idx_d = grt_idx_q;
    unique case (state_q)
      IDLE: begin
        if (enc_vld) begin
          state_d   = LOCK;
          grt_idx_d = winner_c;
        end
      end
      LOCK: begin
        if (xfer_c && grt_lst) begin
          state_d = IDLE;
          if (MODE == ARB_RR) begin
            ptr_d = (grt_idx_q == LAST_IDX) ? '0 : grt_idx_q + WIDTH_LOG'(1);
          end else begin
            ptr_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and locked index; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grt_idx_q <= grt_idx_d;
    end
  end

  a_rdy_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy));

  a_idx_stable: assert property (@(posedge clk) disable iff (!rst_n)
    grt_lck |=> (!grt_lck || $stable(grt_idx)));

endmodule
